// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard that stalls ID on load-use and branch-operand hazards
module hazard_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int REG_AW       = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int ALU_LATENCY  = 0,
  parameter int BRANCH_EXTRA = 1,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_valid,
  input  logic [REG_AW-1:0]      dec_rs1,
  input  logic [REG_AW-1:0]      dec_rs2,
  input  logic                   dec_uses_rs1,
  input  logic                   dec_uses_rs2,
  input  logic                   dec_is_branch,
  input  logic [REG_AW-1:0]      dec_rd,
  input  logic                   dec_writes_rd,
  input  logic                   dec_is_load,
  input  logic                   flush,
  output logic                   stall,
  output logic [1:0]             stall_cause,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  localparam int CW = $clog2(LOAD_LATENCY + BRANCH_EXTRA + 1) > 0 ? $clog2(LOAD_LATENCY + BRANCH_EXTRA + 1) : 1;
  localparam logic [CW-1:0] LD_SET  = CW'(LOAD_LATENCY + BRANCH_EXTRA);
  localparam logic [CW-1:0] ALU_SET = CW'(ALU_LATENCY + BRANCH_EXTRA);
  localparam logic [CW-1:0] BE      = CW'(BRANCH_EXTRA);
  logic [CW-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] ld;
  logic [CW-1:0] c1, c2;
  logic l1, l2, haz1, haz2, acc;
  // x0 and out-of-range indices read as an idle entry so they never hazard
  always_comb begin
    c1 = '0;
    l1 = 1'b0;
    c2 = '0;
    l2 = 1'b0;
    if (dec_rs1 != '0 && int'(dec_rs1) < NUM_REGS) begin
      c1 = cnt[dec_rs1];
      l1 = ld[dec_rs1];
    end
    if (dec_rs2 != '0 && int'(dec_rs2) < NUM_REGS) begin
      c2 = cnt[dec_rs2];
      l2 = ld[dec_rs2];
    end
    haz1 = dec_uses_rs1 & (dec_is_branch ? c1 != '0 : c1 > BE);
    haz2 = dec_uses_rs2 & (dec_is_branch ? c2 != '0 : c2 > BE);
    stall = dec_valid & ~flush & (haz1 | haz2);
    stall_cause = !stall ? 2'b00 : ((haz1 & l1) | (haz2 & l2)) ? 2'b01 : 2'b10;
    acc = dec_valid & ~stall & ~flush;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      ld <= '0;
      stall_cycles <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        if (acc && dec_writes_rd && r != 0 && int'(dec_rd) == r) begin
          cnt[r] <= dec_is_load ? LD_SET : ALU_SET;
          ld[r] <= dec_is_load;
        end else if (cnt[r] != '0) cnt[r] <= cnt[r] - CW'(1);
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized checks of two scoreboard configurations against a timestamp model
module tb_hazard_scoreboard;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic dv, u1, u2, br, wr, isld, fl;
  logic [4:0] rs1, rs2, rd;
  logic stall_a, stall_b;
  logic [1:0] cause_a, cause_b, sc_b;
  logic [31:0] sc_a;
  int vecs = 0, errs = 0;
  longint cyc = 0;
  longint rdy [2][32];
  bit ldm [2][32];
  longint nst [2];
  bit e_st [2];
  logic [1:0] e_ca [2];

  hazard_scoreboard dut_a (
    .clk(clk), .rst(rst), .dec_valid(dv), .dec_rs1(rs1), .dec_rs2(rs2),
    .dec_uses_rs1(u1), .dec_uses_rs2(u2), .dec_is_branch(br), .dec_rd(rd),
    .dec_writes_rd(wr), .dec_is_load(isld), .flush(fl),
    .stall(stall_a), .stall_cause(cause_a), .stall_cycles(sc_a));

  hazard_scoreboard #(.LOAD_LATENCY(3), .BRANCH_EXTRA(0), .STALL_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .dec_valid(dv), .dec_rs1(rs1), .dec_rs2(rs2),
    .dec_uses_rs1(u1), .dec_uses_rs2(u2), .dec_is_branch(br), .dec_rd(rd),
    .dec_writes_rd(wr), .dec_is_load(isld), .flush(fl),
    .stall(stall_b), .stall_cause(cause_b), .stall_cycles(sc_b));

  function automatic int lat_ld(int k); return k == 1 ? 3 : 1; endfunction
  function automatic int be(int k); return k == 1 ? 0 : 1; endfunction

  // a producer's result is ready at cycle rdy; remaining wait is the distance to it
  function automatic bit src_haz(int k, logic [4:0] s, logic en);
    longint rem;
    if (s == 0 || !en) return 1'b0;
    rem = rdy[k][s] > cyc ? rdy[k][s] - cyc : 0;
    return br ? rem > 0 : rem > longint'(be(k));
  endfunction

  function automatic void mdl_eval();
    bit h1, h2;
    for (int k = 0; k < 2; k++) begin
      h1 = src_haz(k, rs1, u1);
      h2 = src_haz(k, rs2, u2);
      e_st[k] = dv && !fl && (h1 || h2);
      e_ca[k] = !e_st[k] ? 2'd0 : ((h1 && ldm[k][rs1]) || (h2 && ldm[k][rs2])) ? 2'd1 : 2'd2;
    end
  endfunction

  task automatic mdl_clear();
    for (int k = 0; k < 2; k++) begin
      nst[k] = 0;
      for (int r = 0; r < 32; r++) begin rdy[k][r] = 0; ldm[k][r] = 1'b0; end
    end
  endtask

  task automatic tick();
    mdl_eval();
    for (int k = 0; k < 2; k++) begin
      if (e_st[k]) nst[k]++;
      if (dv && !fl && !e_st[k] && wr && rd != 0) begin
        rdy[k][rd] = cyc + 1 + (isld ? lat_ld(k) : 0) + be(k);
        ldm[k][rd] = isld;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_i(logic v, logic [4:0] a, logic ua, logic [4:0] b, logic ub, logic bb,
                       logic [4:0] d, logic w, logic l, logic f);
    dv = v; rs1 = a; u1 = ua; rs2 = b; u2 = ub; br = bb; rd = d; wr = w; isld = l; fl = f;
  endtask
  task automatic lw(logic [4:0] d); set_i(1, 0, 1, 0, 0, 0, d, 1, 1, 0); endtask
  task automatic add(logic [4:0] d, logic [4:0] a, logic [4:0] b); set_i(1, a, 1, b, 1, 0, d, 1, 0, 0); endtask
  task automatic brc(logic [4:0] a, logic [4:0] b); set_i(1, a, 1, b, 1, 1, 0, 0, 0, 0); endtask
  task automatic idle(); set_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    mdl_clear();
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #1;
    vecs++; if (stall_a !== 1'b0 || cause_a !== 2'b00 || sc_a !== 32'd0) begin errs++; $display("FAIL reset_a stall=%0b cause=%0d cnt=%0d exp 0 0 0", stall_a, cause_a, sc_a); end
    vecs++; if (stall_b !== 1'b0 || cause_b !== 2'b00 || sc_b !== 2'd0) begin errs++; $display("FAIL reset_b stall=%0b cause=%0d cnt=%0d exp 0 0 0", stall_b, cause_b, sc_b); end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    lw(5); #1;
    vecs++; if (stall_a !== 1'b0) begin errs++; $display("FAIL load_use_lw stall got %0b exp 0", stall_a); end
    tick();
    add(6, 5, 1); #1;
    vecs++; if (stall_a !== 1'b1 || cause_a !== 2'd1) begin errs++; $display("FAIL load_use_stall stall=%0b cause=%0d exp 1 1", stall_a, cause_a); end
    tick(); #1;
    vecs++; if (stall_a !== 1'b0 || sc_a !== 32'd1) begin errs++; $display("FAIL load_use_release stall=%0b cnt=%0d exp 0 1", stall_a, sc_a); end
    tick();
  endtask

  task automatic test_branch_load();
    do_reset();
    lw(5); tick();
    brc(5, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (stall_a !== (i < 2) || cause_a !== (i < 2 ? 2'd1 : 2'd0)) begin errs++; $display("FAIL branch_load[%0d] stall=%0b cause=%0d exp %0b %0d", i, stall_a, cause_a, i < 2, i < 2 ? 1 : 0); end
      tick();
    end
    vecs++; if (sc_a !== 32'd2) begin errs++; $display("FAIL branch_load_cnt got %0d exp 2", sc_a); end
  endtask

  task automatic test_branch_alu();
    do_reset();
    add(7, 1, 1); tick();
    brc(7, 2); #1;
    vecs++; if (stall_a !== 1'b1 || cause_a !== 2'd2) begin errs++; $display("FAIL branch_alu stall=%0b cause=%0d exp 1 2", stall_a, cause_a); end
    tick(); #1;
    vecs++; if (stall_a !== 1'b0) begin errs++; $display("FAIL branch_alu_release stall got %0b exp 0", stall_a); end
    tick();
    add(7, 1, 1); tick();
    add(8, 7, 1); #1;
    vecs++; if (stall_a !== 1'b0) begin errs++; $display("FAIL alu_alu stall got %0b exp 0", stall_a); end
    tick();
  endtask

  task automatic test_x0_unused();
    do_reset();
    lw(0); tick();
    add(1, 0, 0); #1;
    vecs++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin errs++; $display("FAIL x0 stall a=%0b b=%0b exp 0 0", stall_a, stall_b); end
    tick();
    lw(5); tick();
    set_i(1, 5, 0, 0, 1, 0, 6, 1, 0, 0); #1;
    vecs++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin errs++; $display("FAIL unused_rs1 stall a=%0b b=%0b exp 0 0", stall_a, stall_b); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    lw(5); tick();
    set_i(1, 5, 1, 1, 1, 0, 6, 1, 0, 1); #1;
    vecs++; if (stall_a !== 1'b0 || cause_a !== 2'd0) begin errs++; $display("FAIL flush_stall stall=%0b cause=%0d exp 0 0", stall_a, cause_a); end
    tick();
    set_i(1, 0, 1, 0, 1, 0, 8, 1, 1, 1); tick();
    add(9, 8, 1); #1;
    vecs++; if (stall_a !== 1'b0) begin errs++; $display("FAIL flush_no_record stall got %0b exp 0", stall_a); end
    tick();
  endtask

  task automatic test_rst_mid_stall();
    do_reset();
    lw(5); tick();
    brc(5, 0); #1;
    vecs++; if (stall_a !== 1'b1) begin errs++; $display("FAIL rst_mid_pre stall got %0b exp 1", stall_a); end
    tick(); #1;
    vecs++; if (stall_a !== 1'b1 || sc_a !== 32'd1) begin errs++; $display("FAIL rst_mid_pre2 stall=%0b cnt=%0d exp 1 1", stall_a, sc_a); end
    rst = 1'b1; #1;
    vecs++; if (stall_a !== 1'b0 || cause_a !== 2'd0 || sc_a !== 32'd0) begin errs++; $display("FAIL rst_mid stall=%0b cause=%0d cnt=%0d exp 0 0 0", stall_a, cause_a, sc_a); end
    mdl_clear();
    #1 rst = 1'b0;
    add(6, 5, 1); #1;
    vecs++; if (stall_a !== 1'b0) begin errs++; $display("FAIL rst_mid_after stall got %0b exp 0", stall_a); end
    tick();
  endtask

  task automatic test_sweep();
    do_reset();
    lw(9); tick();
    add(3, 9, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++; if (stall_b !== (i < 3) || cause_b !== (i < 3 ? 2'd1 : 2'd0)) begin errs++; $display("FAIL sweep[%0d] stall=%0b cause=%0d exp %0b %0d", i, stall_b, cause_b, i < 3, i < 3 ? 1 : 0); end
      tick();
    end
    vecs++; if (sc_b !== 2'd3) begin errs++; $display("FAIL sweep_cnt got %0d exp 3", sc_b); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lw(9); tick();
    idle(); tick();
    lw(9); #1;
    vecs++; if (stall_b !== 1'b0) begin errs++; $display("FAIL b2b_second_lw stall got %0b exp 0", stall_b); end
    tick();
    add(3, 9, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++; if (stall_b !== (i < 3)) begin errs++; $display("FAIL b2b_restart[%0d] stall got %0b exp %0b", i, stall_b, i < 3); end
      tick();
    end
    lw(10); tick();
    add(4, 10, 1);
    for (int i = 0; i < 4; i++) tick();
    vecs++; if (sc_b !== 2'd3) begin errs++; $display("FAIL saturate got %0d exp 3", sc_b); end
  endtask

  task automatic test_random();
    longint sb;
    do_reset();
    repeat (400) begin
      set_i($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
      #1;
      mdl_eval();
      sb = nst[1] > 3 ? 3 : nst[1];
      vecs++; if (stall_a !== e_st[0] || cause_a !== e_ca[0] || sc_a !== 32'(nst[0])) begin errs++; $display("FAIL random_a cyc=%0d stall=%0b cause=%0d cnt=%0d exp %0b %0d %0d", cyc, stall_a, cause_a, sc_a, e_st[0], e_ca[0], nst[0]); end
      vecs++; if (stall_b !== e_st[1] || cause_b !== e_ca[1] || sc_b !== 2'(sb)) begin errs++; $display("FAIL random_b cyc=%0d stall=%0b cause=%0d cnt=%0d exp %0b %0d %0d", cyc, stall_b, cause_b, sc_b, e_st[1], e_ca[1], sb); end
      tick();
    end
  endtask

  initial begin
    mdl_clear();
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_x0_unused();
    test_flush();
    test_rst_mid_stall();
    test_sweep();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
